muldiv_ctrl: RTL and testbench
==============================

Name: muldiv_ctrl

Overview:
Sequencer for the iterative multiply/divide unit that feeds the HI/LO path, i.e. the 64-bit mult result and multWr flag carried down the pipeline to write-back.
- Accepts mult/div requests from the EX stage and times the unit's fixed-latency operation.
- Strobes the result into the pipeline.
- Raises a stall request whenever a younger instruction touches HI/LO or the unit while an operation is in flight.

Parameters:
MULT_CYCLES, 4, execution cycles for MULT/MULTU (min 1)
DIV_CYCLES, 32, execution cycles for DIV/DIVU (min 1)
CNT_W, 6, counter width; must satisfy 2^CNT_W > max(MULT_CYCLES, DIV_CYCLES)

Ports:
clk  input  1  pipeline clock, rising edge
rst  input  1  asynchronous, active-high reset
req_mult  input  1  EX holds MULT/MULTU this cycle
req_div  input  1  EX holds DIV/DIVU this cycle
req_signed  input  1  signed variant (MULT/DIV) when 1
req_dz  input  1  divisor operand is zero (qualified by req_div)
req_hilo_rd  input  1  EX holds MFHI/MFLO
req_hilo_wr  input  1  EX holds MTHI/MTLO
flush  input  1  kill the in-flight operation (exception on its own instruction)
unit_start  output  1  one-cycle start pulse to the mult/div unit
unit_op  output  2  00 MULTU, 01 MULT, 10 DIVU, 11 DIV; latched at accept
busy  output  1  state != IDLE
stall_req  output  1  freeze IF/ID/EX this cycle
res_valid  output  1  one-cycle strobe; drives multWr of the instruction entering MEM
div_zero  output  1  last accepted DIV/DIVU had a zero divisor

Behaviour:
- Reset (async, any state): state=IDLE, cnt=0, unit_start=0, unit_op=00, div_zero=0. busy, stall_req and res_valid are then 0 combinationally.
- FSM states: IDLE, RUN, DONE.
- IDLE: request accepted at a rising edge when (req_mult|req_div) & ~flush.
  - req_mult has priority if both requests are high.
  - On accept: state->RUN; cnt = N-1, where N = MULT_CYCLES or DIV_CYCLES.
  - unit_op = {req_div&~req_mult, req_signed}.
  - div_zero = req_div & ~req_mult & req_dz.
  - unit_start is registered and high for exactly the first RUN cycle.
- RUN: cnt decrements each edge. If cnt==0 at an edge, state->DONE.
- DONE: res_valid high for this single cycle, then state->IDLE.
- Latency: request high in cycle 0 -> unit_start in cycle 1 -> RUN occupies cycles 1..N -> res_valid in cycle N+1 -> IDLE in cycle N+2.
- stall_req = busy & (req_mult | req_div | req_hilo_rd | req_hilo_wr). This is combinational and includes the DONE cycle, so MFHI/MFLO never reads stale HI/LO.
- No stall when idle: a request in IDLE is accepted with stall_req=0 in that cycle.
- Back-to-back: a second mult/div arriving during RUN/DONE is stalled and accepted at the edge ending its first IDLE cycle (not the DONE->IDLE edge).
- flush in RUN or DONE: state->IDLE at the next edge.
  - res_valid = (state==DONE) & ~flush, so a flushed result is never strobed.
  - unit_op and div_zero are retained.
- flush in IDLE blocks acceptance that cycle.
- Independent inputs: req_signed and req_dz are ignored unless a request is accepted.
- Divide-by-zero: still runs the full DIV_CYCLES. The HI/LO content is undefined; only div_zero is flagged, and it holds until the next accept.
- cnt never wraps: it is loaded only on accept and frozen at 0 outside RUN.

Test Plan:
- Reset mid-RUN: MULT accepted, assert rst in cycle 2 -> busy=0 and unit_start=0 immediately (async), unit_op=00, no res_valid after release.
- Single MULT (MULT_CYCLES=4, req_signed=1) in cycle 0 -> unit_start in cycle 1 only, unit_op=01, busy high cycles 1..5, res_valid in cycle 5 only, stall_req=0 in cycle 0.
- MFHI issued in cycle 2 after a DIVU (DIV_CYCLES=32) in cycle 0 -> stall_req high cycles 2..33 (DONE = cycle 33), low in cycle 34; res_valid in cycle 33.
- Back-to-back: MULT in cycle 0, DIV held from cycle 1 -> stall_req high cycles 1..5; DIV accepted at end of cycle 6; second unit_start in cycle 7 with unit_op=11.
- Flush: DIV accepted in cycle 0, flush in cycle 10 -> busy=0 in cycle 11, res_valid never asserts; a request in the flush cycle is not accepted.
- Divide by zero: DIV with req_dz=1 -> div_zero=1 from cycle 1, res_valid still in cycle 33; a subsequent MULTU clears div_zero at its accept edge.

Source files
------------

// File: rtl/muldiv_ctrl.sv
// muldiv_ctrl
//   Sequencer for the iterative multiply/divide unit feeding the HI/LO path.
//   Accepts MULT/MULTU/DIV/DIVU from EX, times the fixed-latency operation,
//   strobes the result (multWr) into the pipeline and requests a front-end
//   stall while a younger instruction touches HI/LO or the unit.
//
// Parameters
//   MULT_CYCLES : execution cycles for MULT/MULTU (>= 1)
//   DIV_CYCLES  : execution cycles for DIV/DIVU   (>= 1)
//   CNT_W       : counter width, 2**CNT_W > max(MULT_CYCLES, DIV_CYCLES)
//
// Ports
//   clk, rst      : clock (rising edge), asynchronous active-high reset
//   req_mult      : EX holds MULT/MULTU
//   req_div       : EX holds DIV/DIVU
//   req_signed    : signed variant
//   req_dz        : divisor operand is zero (meaningful with req_div)
//   req_hilo_rd   : EX holds MFHI/MFLO
//   req_hilo_wr   : EX holds MTHI/MTLO
//   flush         : kill the in-flight operation / block acceptance
//   unit_start    : one-cycle start pulse to the arithmetic unit
//   unit_op       : 00 MULTU, 01 MULT, 10 DIVU, 11 DIV (latched at accept)
//   busy          : FSM not idle
//   stall_req     : freeze IF/ID/EX this cycle
//   res_valid     : one-cycle result strobe (multWr)
//   div_zero      : last accepted divide had a zero divisor
//
// Handshake: EX presents a request (req_mult/req_div) and holds it while
// stall_req is high. A request is consumed at the rising edge of a cycle in
// which the FSM is IDLE and flush is low; in IDLE stall_req is always low, so
// "accepted" and "not stalled" coincide for the requesting instruction.

module muldiv_ctrl #(
    parameter int MULT_CYCLES = 4,
    parameter int DIV_CYCLES  = 32,
    parameter int CNT_W       = 6
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_mult,
    input  logic       req_div,
    input  logic       req_signed,
    input  logic       req_dz,
    input  logic       req_hilo_rd,
    input  logic       req_hilo_wr,
    input  logic       flush,
    output logic       unit_start,
    output logic [1:0] unit_op,
    output logic       busy,
    output logic       stall_req,
    output logic       res_valid,
    output logic       div_zero
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

    // Counter reload values: RUN lasts N cycles, so the counter starts at N-1
    // and the FSM leaves RUN on the edge where it reads zero.
    localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES - 1);
    localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES - 1);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             accept;

    assign accept = (state == IDLE) & (req_mult | req_div) & ~flush;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            unit_start <= 1'b0;
            unit_op    <= 2'b00;
            div_zero   <= 1'b0;
        end else begin
            // High exactly for the first RUN cycle.
            unit_start <= accept;
            case (state)
                IDLE: begin
                    if (accept) begin
                        state    <= RUN;
                        cnt      <= req_mult ? MULT_LOAD : DIV_LOAD;
                        // MULT wins when both requests are present.
                        unit_op  <= {req_div & ~req_mult, req_signed};
                        div_zero <= req_div & ~req_mult & req_dz;
                    end
                end
                RUN: begin
                    if (flush) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end else if (cnt == '0) begin
                        state <= DONE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                DONE: begin
                    // Counter is already zero here; flush or not, go idle.
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

    assign busy      = (state != IDLE);
    // Includes DONE so MFHI/MFLO cannot slip past a result not yet written.
    assign stall_req = busy & (req_mult | req_div | req_hilo_rd | req_hilo_wr);
    // A flushed result must never be written back.
    assign res_valid = (state == DONE) & ~flush;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Testbench for muldiv_ctrl: table of single-operation vectors with
// per-cycle timing checks, hand-written sequences for reset, stall,
// back-to-back and flush corner cases, and a result scoreboard.
module tb_muldiv_ctrl;

    localparam int MC = 4;
    localparam int DC = 32;

    logic       clk = 1'b0;
    logic       rst;
    logic       req_mult, req_div, req_signed, req_dz;
    logic       req_hilo_rd, req_hilo_wr, flush;
    logic       unit_start, busy, stall_req, res_valid, div_zero;
    logic [1:0] unit_op;

    muldiv_ctrl #(.MULT_CYCLES(MC), .DIV_CYCLES(DC), .CNT_W(6)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_mult   (req_mult),
        .req_div    (req_div),
        .req_signed (req_signed),
        .req_dz     (req_dz),
        .req_hilo_rd(req_hilo_rd),
        .req_hilo_wr(req_hilo_wr),
        .flush      (flush),
        .unit_start (unit_start),
        .unit_op    (unit_op),
        .busy       (busy),
        .stall_req  (stall_req),
        .res_valid  (res_valid),
        .div_zero   (div_zero)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- bookkeeping ----------------
    int n_checks = 0;
    int n_fail   = 0;
    // {unit_op, div_zero} expected at each res_valid strobe
    logic [2:0] exp_q[$];

    typedef struct {
        logic       m;
        logic       d;
        logic       s;
        logic       dz;
        logic [1:0] op;
        logic       ezd;
        int         n;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input int c, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got %0h expected %0h (t=%0t)", name, c, act, exp, $time);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic idle_inputs();
        req_mult    = 1'b0;
        req_div     = 1'b0;
        req_hilo_rd = 1'b0;
        req_hilo_wr = 1'b0;
        flush       = 1'b0;
        // These must be ignored unless a request is accepted.
        req_signed  = 1'($urandom_range(0, 1));
        req_dz      = 1'($urandom_range(0, 1));
    endtask

    task automatic advance();
        @(posedge clk);
        #1;
    endtask

    // Sample mid-cycle and check the four timing outputs.
    task automatic run_check(input string tag, input int c, input bit e_start,
                             input bit e_busy, input bit e_stall, input bit e_rv);
        @(negedge clk);
        chk({tag, ".unit_start"}, c, 8'(unit_start), 8'(e_start));
        chk({tag, ".busy"},       c, 8'(busy),       8'(e_busy));
        chk({tag, ".stall_req"},  c, 8'(stall_req),  8'(e_stall));
        chk({tag, ".res_valid"},  c, 8'(res_valid),  8'(e_rv));
    endtask

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        if (!rst && res_valid) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL sb.unexpected_res_valid: got strobe expected none (t=%0t)", $time);
            end else begin
                logic [2:0] e;
                e = exp_q.pop_front();
                if ({unit_op, div_zero} !== e) begin
                    n_fail++;
                    $display("FAIL sb.result: got op=%0b dz=%0b expected op=%0b dz=%0b (t=%0t)",
                             unit_op, div_zero, e[2:1], e[0], $time);
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [1:0] prev_op;
        logic       prev_dz;
        bit         e_busy;

        vecs[0] = '{m:1'b1, d:1'b0, s:1'b0, dz:1'b0, op:2'b00, ezd:1'b0, n:MC}; // MULTU
        vecs[1] = '{m:1'b1, d:1'b0, s:1'b1, dz:1'b0, op:2'b01, ezd:1'b0, n:MC}; // MULT
        vecs[2] = '{m:1'b0, d:1'b1, s:1'b0, dz:1'b0, op:2'b10, ezd:1'b0, n:DC}; // DIVU
        vecs[3] = '{m:1'b0, d:1'b1, s:1'b1, dz:1'b0, op:2'b11, ezd:1'b0, n:DC}; // DIV
        vecs[4] = '{m:1'b0, d:1'b1, s:1'b1, dz:1'b1, op:2'b11, ezd:1'b1, n:DC}; // DIV /0
        vecs[5] = '{m:1'b1, d:1'b1, s:1'b1, dz:1'b1, op:2'b01, ezd:1'b0, n:MC}; // both: MULT wins
        vecs[6] = '{m:1'b0, d:1'b1, s:1'b0, dz:1'b1, op:2'b10, ezd:1'b1, n:DC}; // DIVU /0
        vecs[7] = '{m:1'b1, d:1'b0, s:1'b0, dz:1'b1, op:2'b00, ezd:1'b0, n:MC}; // MULTU, dz ignored

        // ---- reset state ----
        rst = 1'b1;
        idle_inputs();
        #2;
        chk("rst.busy",       0, 8'(busy),       8'd0);
        chk("rst.stall_req",  0, 8'(stall_req),  8'd0);
        chk("rst.res_valid",  0, 8'(res_valid),  8'd0);
        chk("rst.unit_start", 0, 8'(unit_start), 8'd0);
        chk("rst.unit_op",    0, 8'(unit_op),    8'd0);
        chk("rst.div_zero",   0, 8'(div_zero),   8'd0);
        advance();
        advance();
        rst = 1'b0;

        // ---- reset mid-RUN (async) ----
        idle_inputs();
        req_mult = 1'b1; req_signed = 1'b1;
        run_check("rstrun", 0, 0, 0, 0, 0);
        advance();
        idle_inputs();
        run_check("rstrun", 1, 1, 1, 0, 0);
        chk("rstrun.unit_op", 1, 8'(unit_op), 8'd1);
        advance();
        rst = 1'b1;
        #1;
        chk("rstrun.async_busy",     2, 8'(busy),       8'd0);
        chk("rstrun.async_start",    2, 8'(unit_start), 8'd0);
        chk("rstrun.async_unit_op",  2, 8'(unit_op),    8'd0);
        chk("rstrun.async_div_zero", 2, 8'(div_zero),   8'd0);
        advance();
        rst = 1'b0;
        for (int c = 0; c < 8; c++) begin
            idle_inputs();
            run_check("rstrun.after", c, 0, 0, 0, 0);
            advance();
        end

        // ---- table of single operations ----
        prev_op = 2'b00;
        prev_dz = 1'b0;
        for (int i = 0; i < 8; i++) begin
            int gap;
            gap = $urandom_range(0, 2);
            for (int g = 0; g < gap; g++) begin
                idle_inputs();
                run_check("vec.gap", g, 0, 0, 0, 0);
                advance();
            end
            for (int c = 0; c <= vecs[i].n + 2; c++) begin
                idle_inputs();
                req_hilo_rd = ($urandom_range(0, 3) == 0);
                if (c == 0) begin
                    req_mult   = vecs[i].m;
                    req_div    = vecs[i].d;
                    req_signed = vecs[i].s;
                    req_dz     = vecs[i].dz;
                    exp_q.push_back({vecs[i].op, vecs[i].ezd});
                end
                e_busy = (c >= 1) && (c <= vecs[i].n + 1);
                run_check($sformatf("vec%0d", i), c, (c == 1), e_busy,
                          e_busy && req_hilo_rd, (c == vecs[i].n + 1));
                chk($sformatf("vec%0d.unit_op", i), c, 8'(unit_op),
                    8'((c == 0) ? prev_op : vecs[i].op));
                chk($sformatf("vec%0d.div_zero", i), c, 8'(div_zero),
                    8'((c == 0) ? prev_dz : vecs[i].ezd));
                advance();
            end
            prev_op = vecs[i].op;
            prev_dz = vecs[i].ezd;
        end

        // ---- MFHI behind DIVU: stall through DONE ----
        for (int c = 0; c <= 35; c++) begin
            idle_inputs();
            if (c == 0) begin
                req_div = 1'b1; req_signed = 1'b0; req_dz = 1'b0;
                exp_q.push_back({2'b10, 1'b0});
            end
            if (c >= 2 && c <= 34) req_hilo_rd = 1'b1;
            run_check("mfhi", c, (c == 1), (c >= 1 && c <= 33), (c >= 2 && c <= 33), (c == 33));
            advance();
        end

        // ---- MTHI behind MULTU ----
        for (int c = 0; c <= 7; c++) begin
            idle_inputs();
            if (c == 0) begin
                req_mult = 1'b1; req_signed = 1'b0;
                exp_q.push_back({2'b00, 1'b0});
            end
            if (c >= 1 && c <= 6) req_hilo_wr = 1'b1;
            run_check("mthi", c, (c == 1), (c >= 1 && c <= 5), (c >= 1 && c <= 5), (c == 5));
            advance();
        end

        // ---- back-to-back: MULT then held DIV ----
        for (int c = 0; c <= 40; c++) begin
            idle_inputs();
            if (c == 0) begin
                req_mult = 1'b1; req_signed = 1'b1;
                exp_q.push_back({2'b01, 1'b0});
            end
            if (c >= 1 && c <= 6) begin
                req_div = 1'b1; req_signed = 1'b1; req_dz = 1'b0;
            end
            if (c == 6) exp_q.push_back({2'b11, 1'b0});
            run_check("b2b", c, (c == 1 || c == 7),
                      (c >= 1 && c <= 5) || (c >= 7 && c <= 39),
                      (c >= 1 && c <= 5), (c == 5 || c == 39));
            if (c == 2) chk("b2b.unit_op_first", c, 8'(unit_op), 8'd1);
            if (c == 7) chk("b2b.unit_op_second", c, 8'(unit_op), 8'd3);
            advance();
        end

        // ---- flush in RUN, then flush blocks an IDLE request ----
        for (int c = 0; c <= 12; c++) begin
            idle_inputs();
            if (c == 0) begin
                req_div = 1'b1; req_signed = 1'b1; req_dz = 1'b1;
            end
            if (c == 10 || c == 11) begin
                flush = 1'b1; req_mult = 1'b1; req_signed = 1'b0;
            end
            run_check("flush_run", c, (c == 1), (c >= 1 && c <= 10), (c == 10), 0);
            if (c >= 11) begin
                chk("flush_run.unit_op_kept", c, 8'(unit_op), 8'd3);
                chk("flush_run.div_zero_kept", c, 8'(div_zero), 8'd1);
            end
            advance();
        end

        // ---- flush in DONE: result suppressed ----
        for (int c = 0; c <= 7; c++) begin
            idle_inputs();
            if (c == 0) begin
                req_mult = 1'b1; req_signed = 1'b0; req_dz = 1'b1;
            end
            if (c == 5) flush = 1'b1;
            run_check("flush_done", c, (c == 1), (c >= 1 && c <= 5), 0, 0);
            if (c >= 1) chk("flush_done.div_zero_cleared", c, 8'(div_zero), 8'd0);
            advance();
        end

        // ---- final report ----
        idle_inputs();
        advance();
        chk("sb.pending", 0, 8'(exp_q.size()), 8'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
